// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the iterative ALU.
//   op_e    - opcode encoding used when op_cmp=0 (8..13 are unassigned and
//             fall through to "pass A").
//   state_e - control FSM states of alu_iter.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_LSH = 4'd2,
        OP_RSH = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_OR  = 4'd6,
        OP_PAR = 4'd7,
        OP_TGB = 4'd14,
        OP_ASR = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // True for the opcodes that go through the iterative shifter.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_LSH) || (op == OP_RSH) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: purely combinational part of the ALU.
// Computes every single-cycle operation, compare mode and the flags.
// For the shift opcodes it returns B unchanged, which is the correct result
// for a shift amount of zero; nonzero shifts are handled by alu_iter.
// Ports:
//   op, op_cmp   - opcode and compare-mode select
//   a, b         - operands (a also serves as bit index for TGB)
//   result       - WIDTH-bit result
//   zero         - compare: a==b; otherwise result==0
//   less_than    - compare only: b<a unsigned
//   carry        - ADD/SUB only: bit WIDTH of the extended sum
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic             op_cmp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             less_than,
    output logic             carry
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] tgb_mask;
    logic             parity;

    // SUB is a + ~b + 1, so carry=1 means "no borrow".
    assign add_sum = {1'b0, b} + {1'b0, a};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign parity  = ^a;

    // One-hot mask selecting bit a; all zero when a>=WIDTH, so TGB then
    // leaves b untouched without a separate range check.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tgb_mask
            assign tgb_mask[gi] = (a == WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        result    = '0;
        zero      = 1'b0;
        less_than = 1'b0;
        carry     = 1'b0;
        if (op_cmp) begin
            zero      = (a == b);
            less_than = (b < a);
        end else begin
            case (op)
                OP_ADD: begin
                    result = add_sum[WIDTH-1:0];
                    carry  = add_sum[WIDTH];
                end
                OP_SUB: begin
                    result = sub_sum[WIDTH-1:0];
                    carry  = sub_sum[WIDTH];
                end
                OP_LSH, OP_RSH, OP_ASR: result = b;
                OP_XOR: result = a ^ b;
                OP_AND: result = a & b;
                OP_OR:  result = a | b;
                OP_PAR: result = {{(WIDTH-1){1'b0}}, parity};
                OP_TGB: result = b ^ tgb_mask;
                default: result = a;
            endcase
            zero = (result == '0);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with valid/ready on both sides.
// Single-cycle operations and compare are registered in one cycle; LSH, RSH
// and ASR shift a working register one bit per cycle, so a shift of n bits
// (n clamped to WIDTH) takes n+1 cycles from accept to out_valid.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid / in_ready  - operation handshake (accept in IDLE only)
//   op, op_cmp           - opcode and compare-mode select
//   input_a, input_b     - operands; input_a is also shift amount / bit index
//   out_valid/out_ready  - result handshake; result held until taken
//   out, zero, less_than, carry - registered result and flags
//   busy                 - high while an operation is in flight (SHIFT/DONE)
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             op_cmp,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             less_than,
    output logic             carry,
    output logic             busy
);

    localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);
    localparam logic [SHW-1:0] CNT_MAX   = SHW'(WIDTH);
    localparam logic [SHW-1:0] CNT_ONE   = SHW'(1);

    state_e           state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [3:0]       sop_reg;
    logic [WIDTH-1:0] out_reg;
    logic             zero_reg;
    logic             lt_reg;
    logic             carry_reg;

    logic [WIDTH-1:0] core_result;
    logic             core_zero;
    logic             core_lt;
    logic             core_carry;

    logic [SHW-1:0]   amount;
    logic             start_shift;
    logic [WIDTH-1:0] shreg_next;

    alu_core_comb #(
        .WIDTH(WIDTH)
    ) u_core (
        .op        (op),
        .op_cmp    (op_cmp),
        .a         (input_a),
        .b         (input_b),
        .result    (core_result),
        .zero      (core_zero),
        .less_than (core_lt),
        .carry     (core_carry)
    );

    // Shifting by WIDTH or more gives the same answer as shifting by WIDTH,
    // so the counter never needs more than SHW bits.
    assign amount = ({1'b0, input_a} >= WIDTH_EXT) ? CNT_MAX : input_a[SHW-1:0];

    // A zero-amount shift is just "pass B", which the core already provides.
    assign start_shift = !op_cmp && is_shift_op(op) && (amount != '0);

    // One-bit step in the direction and fill of the captured shift op.
    always_comb begin
        shreg_next = shreg_reg;
        case (sop_reg)
            OP_LSH:  shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
            OP_RSH:  shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
            OP_ASR:  shreg_next = {shreg_reg[WIDTH-1], shreg_reg[WIDTH-1:1]};
            default: shreg_next = shreg_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shreg_reg <= '0;
            sop_reg   <= '0;
            out_reg   <= '0;
            zero_reg  <= 1'b0;
            lt_reg    <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready is exactly "IDLE and not in reset", and reset
                    // is excluded by this branch, so in_valid alone accepts.
                    if (in_valid) begin
                        if (start_shift) begin
                            shreg_reg <= input_b;
                            cnt_reg   <= amount;
                            sop_reg   <= op;
                            state_reg <= SHIFT;
                        end else begin
                            out_reg   <= core_result;
                            zero_reg  <= core_zero;
                            lt_reg    <= core_lt;
                            carry_reg <= core_carry;
                            state_reg <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shreg_reg <= shreg_next;
                    cnt_reg   <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        out_reg   <= shreg_next;
                        zero_reg  <= (shreg_next == '0);
                        lt_reg    <= 1'b0;
                        carry_reg <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out       = out_reg;
    assign zero      = zero_reg;
    assign less_than = lt_reg;
    assign carry     = carry_reg;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = '0;
    logic             op_cmp = 1'b0;
    logic [WIDTH-1:0] input_a = '0;
    logic [WIDTH-1:0] input_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             less_than;
    logic             carry;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_cmp    (op_cmp),
        .input_a   (input_a),
        .input_b   (input_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .less_than (less_than),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: result straight from the arithmetic meaning of each op.
    task automatic model(input logic [3:0] o, input logic cm, input logic [7:0] a,
                         input logic [7:0] b, output logic [7:0] r, output logic z,
                         output logic lt, output logic c, output int lat);
        int amt;
        int s;
        int sb;
        amt = (a >= 8) ? 8 : int'(a);
        lat = 1;
        lt  = 1'b0;
        c   = 1'b0;
        r   = 8'h00;
        if (cm) begin
            z  = (a == b);
            lt = (b < a);
        end else begin
            case (o)
                4'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s >= 256); end
                4'd1: begin s = int'(a) + (255 - int'(b)) + 1; r = 8'(s); c = (s >= 256); end
                4'd2: r = 8'((int'(b) << amt) & 255);
                4'd3: r = 8'(int'(b) >> amt);
                4'd4: r = a ^ b;
                4'd5: r = a & b;
                4'd6: r = a | b;
                4'd7: r = 8'($countones(a) % 2);
                4'd14: r = (a < 8) ? (b ^ 8'(1 << a)) : b;
                4'd15: begin
                    sb = (b >= 128) ? int'(b) - 256 : int'(b);
                    r  = 8'(sb >>> amt);
                end
                default: r = a;
            endcase
            if ((o == 4'd2 || o == 4'd3 || o == 4'd15) && amt > 0) lat = amt + 1;
            z = (r == 8'h00);
        end
    endtask

    // Present one op, wait for acceptance and then for out_valid (bounded).
    // cycles counts edges from the accept edge (1 = result right after accept).
    // stall_ok records whether busy=1 and in_ready=0 held while waiting.
    task automatic issue(input logic [3:0] o, input logic cm, input logic [7:0] a,
                         input logic [7:0] b, output int cycles, output bit stall_ok);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        op = o; op_cmp = cm; input_a = a; input_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); op_cmp = 1'($urandom);
        input_a = 8'($urandom); input_b = 8'($urandom);
        cycles = 1;
        stall_ok = 1'b1;
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
            @(posedge clk); #1; cycles++;
        end
        $display("op=%0d cmp=%0d a=%02h b=%02h -> out=%02h z=%b lt=%b c=%b after %0d cycles",
                 o, cm, a, b, out, zero, less_than, carry, cycles);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Issue an op, compare every output with the model, and release it.
    task automatic run_and_check(input string name, input logic [3:0] o, input logic cm,
                                 input logic [7:0] a, input logic [7:0] b);
        logic [7:0] er;
        logic ez, elt, ec;
        int elat, cyc;
        bit st;
        model(o, cm, a, b, er, ez, elt, ec, elat);
        issue(o, cm, a, b, cyc, st);
        n_checks++;
        if (cyc !== elat) begin
            n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, elat);
        end
        n_checks++;
        if (out !== er) begin
            n_fail++; $display("FAIL %s out: got %02h expected %02h", name, out, er);
        end
        n_checks++;
        if ({zero, less_than, carry} !== {ez, elt, ec}) begin
            n_fail++; $display("FAIL %s flags z/lt/c: got %b%b%b expected %b%b%b",
                               name, zero, less_than, carry, ez, elt, ec);
        end
        n_checks++;
        if (!st) begin
            n_fail++; $display("FAIL %s stall: busy/in_ready wrong while waiting (got 0 expected 1)", name);
        end
        take();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({in_ready, out_valid, busy, out, zero, less_than, carry} !== 13'b0) begin
            n_fail++; $display("FAIL reset_state: got rdy=%b vld=%b busy=%b out=%02h flags=%b%b%b expected all 0",
                               in_ready, out_valid, busy, out, zero, less_than, carry);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_compare();
        run_and_check("cmp_10_1", 4'd0, 1'b1, 8'd10, 8'd1);
        run_and_check("cmp_255_255", 4'd3, 1'b1, 8'd255, 8'd255);
    endtask

    task automatic test_add_sub();
        run_and_check("add_ff_01", 4'd0, 1'b0, 8'hFF, 8'h01);
        run_and_check("sub_01_02", 4'd1, 1'b0, 8'h01, 8'h02);
    endtask

    task automatic test_shift();
        run_and_check("lsh_3", 4'd2, 1'b0, 8'd3, 8'h0A);
        run_and_check("rsh_0", 4'd3, 1'b0, 8'd0, 8'h55);
        run_and_check("asr_9", 4'd15, 1'b0, 8'd9, 8'hAA);
        run_and_check("asr_2", 4'd15, 1'b0, 8'd2, 8'h2A);
        run_and_check("lsh_200", 4'd2, 1'b0, 8'd200, 8'hFF);
        run_and_check("rsh_8", 4'd3, 1'b0, 8'd8, 8'h80);
    endtask

    task automatic test_hold();
        int cyc;
        bit st;
        bit held;
        issue(4'd14, 1'b0, 8'd0, 8'hAA, cyc, st);
        held = 1'b1;
        // Offer a competing op while the result waits; it must not be taken.
        op = 4'd0; op_cmp = 1'b0; input_a = 8'd1; input_b = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out !== 8'hAB || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0)
                held = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!held || out !== 8'hAB) begin
            n_fail++; $display("FAIL tgb_hold: got out=%02h vld=%b rdy=%b held=%b expected out=ab vld=1 rdy=0 held=1",
                               out, out_valid, in_ready, held);
        end
        take();
        run_and_check("par_ab", 4'd7, 1'b0, 8'hAB, 8'h00);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit st;
        issue(4'd4, 1'b0, 8'h0F, 8'h3C, cyc, st);
        out_ready = 1'b1;
        op = 4'd5; op_cmp = 1'b0; input_a = 8'hF0; input_b = 8'h3C; in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_accept_in_done: got in_ready=%b expected 0", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out !== 8'h30) begin
            n_fail++; $display("FAIL b2b_second: got vld=%b out=%02h expected vld=1 out=30", out_valid, out);
        end
        take();
    endtask

    task automatic test_reset_abort();
        bit seen;
        op = 4'd2; op_cmp = 1'b0; input_a = 8'd7; input_b = 8'h81; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_immediate: got vld=%b busy=%b rdy=%b expected 0 0 0",
                               out_valid, busy, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_release in_ready: got %b expected 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_valid: got out_valid=1 expected 0");
        end
        run_and_check("add_after_abort", 4'd0, 1'b0, 8'd3, 8'd4);
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic cm;
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            cm = ($urandom_range(0, 4) == 0);
            o  = 4'($urandom);
            b  = 8'($urandom);
            a  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            run_and_check("random", o, cm, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_add_sub();
        test_shift();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
